// File: rtl/flagram_ctrl.sv
// Round-robin two-requester sequencer in front of a 16x4 flag RAM.
// One op per three cycles: IDLE grant, ISSUE strobe, RESP done pulse.
module flagram_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 4
) (
  input  logic                  i_w_clk,
  input  logic                  i_w_reset,
  input  logic                  i_w_req_a,
  input  logic [1:0]            i_w_op_a,
  input  logic [ADDR_WIDTH-1:0] i_w_addr_a,
  input  logic [DATA_WIDTH-1:0] i_w_data_a,
  input  logic                  i_w_req_b,
  input  logic [1:0]            i_w_op_b,
  input  logic [ADDR_WIDTH-1:0] i_w_addr_b,
  input  logic [DATA_WIDTH-1:0] i_w_data_b,
  output logic                  o_w_done_a,
  output logic                  o_w_done_b,
  output logic                  o_w_err,
  output logic [DATA_WIDTH-1:0] o_w_rdata,
  output logic                  o_w_busy,
  output logic [ADDR_WIDTH-1:0] o_w_ram_address,
  output logic [DATA_WIDTH-1:0] o_w_ram_data,
  output logic                  o_w_ram_we,
  output logic                  o_w_ram_oe,
  output logic                  o_w_ram_flags_out,
  input  logic [DATA_WIDTH-1:0] i_w_ram_out
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_t;

  localparam logic [1:0] OP_RD  = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_FL  = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  state_t                state_q, state_d;
  logic [1:0]            op_q, op_d;
  logic                  id_q, id_d;
  logic                  last_q, last_d;
  logic                  done_a_q, done_a_d;
  logic                  done_b_q, done_b_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  busy_q, busy_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic [DATA_WIDTH-1:0] rdat_q, rdat_d;
  logic                  we_q, we_d;
  logic                  oe_q, oe_d;
  logic                  fl_q, fl_d;

  logic                  win_b;
  logic [1:0]            sel_op;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;

  // last_q=1 means B was served last, so A wins a tie
  assign win_b    = i_w_req_b & (~i_w_req_a | ~last_q);
  assign sel_op   = win_b ? i_w_op_b   : i_w_op_a;
  assign sel_addr = win_b ? i_w_addr_b : i_w_addr_a;
  assign sel_data = win_b ? i_w_data_b : i_w_data_a;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    id_d     = id_q;
    last_d   = last_q;
    done_a_d = 1'b0;
    done_b_d = 1'b0;
    err_d    = 1'b0;
    rdata_d  = rdata_q;
    busy_d   = busy_q;
    raddr_d  = raddr_q;
    rdat_d   = rdat_q;
    we_d     = 1'b0;
    oe_d     = 1'b0;
    fl_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_w_req_a | i_w_req_b) begin
          state_d = ISSUE;
          op_d    = sel_op;
          id_d    = win_b;
          busy_d  = 1'b1;
          raddr_d = sel_addr;
          we_d    = (sel_op == OP_WR);
          oe_d    = (sel_op == OP_RD);
          fl_d    = (sel_op == OP_FL);
          if (sel_op == OP_WR) rdat_d = sel_data;
        end
      end
      ISSUE: begin
        state_d  = RESP;
        done_a_d = ~id_q;
        done_b_d = id_q;
        err_d    = (op_q == OP_RSV);
        if (op_q == OP_RD || op_q == OP_FL) rdata_d = i_w_ram_out;
      end
      RESP: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        last_d  = id_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_w_clk) begin
    if (i_w_reset) begin
      state_q  <= IDLE;
      op_q     <= 2'b00;
      id_q     <= 1'b0;
      last_q   <= 1'b1;
      done_a_q <= 1'b0;
      done_b_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      busy_q   <= 1'b0;
      raddr_q  <= '0;
      rdat_q   <= '0;
      we_q     <= 1'b0;
      oe_q     <= 1'b0;
      fl_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      id_q     <= id_d;
      last_q   <= last_d;
      done_a_q <= done_a_d;
      done_b_q <= done_b_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      busy_q   <= busy_d;
      raddr_q  <= raddr_d;
      rdat_q   <= rdat_d;
      we_q     <= we_d;
      oe_q     <= oe_d;
      fl_q     <= fl_d;
    end
  end

  assign o_w_done_a        = done_a_q;
  assign o_w_done_b        = done_b_q;
  assign o_w_err           = err_q;
  assign o_w_rdata         = rdata_q;
  assign o_w_busy          = busy_q;
  assign o_w_ram_address   = raddr_q;
  assign o_w_ram_data      = rdat_q;
  assign o_w_ram_we        = we_q;
  assign o_w_ram_oe        = oe_q;
  assign o_w_ram_flags_out = fl_q;

endmodule
